// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding, reset PC default and alignment mask
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [1:0]  ALIGN_MASK   = 2'b11;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory port, decode handshake and status bundle of the fetch stage
interface fetch_unit_if;

    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemRespValid;
    logic [31:0] IMemRData;
    logic [31:0] NextPC;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] CurrentPC;
    logic        InstrAccept;
    logic        AddrErr;
    logic        FetchTimeout;
    logic [31:0] RetiredCount;

    modport master (
        output IMemReq, IMemAddr, InstrValid, Instr, CurrentPC,
               AddrErr, FetchTimeout, RetiredCount,
        input  IMemReady, IMemRespValid, IMemRData, NextPC, InstrAccept
    );

    modport slave (
        input  IMemReq, IMemAddr, InstrValid, Instr, CurrentPC,
               AddrErr, FetchTimeout, RetiredCount,
        output IMemReady, IMemRespValid, IMemRData, NextPC, InstrAccept
    );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// fetch_unit_pc_reg: 32-bit PC register with load enable and parameterised reset value
module fetch_unit_pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // Load the next PC only when the held instruction is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_q <= RESET_VAL;
        else if (load_i) pc_q <= d_i;
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder that fetches from handshaked memory and hands words to decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          MAX_WAIT = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   retired_q, retired_d;
    logic          addr_err_q, addr_err_d;
    logic          timeout_q, timeout_d;
    logic          pc_load;
    logic [31:0]   pc;
    logic          misaligned;

    fetch_unit_pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (pc_load),
        .d_i     (bus.NextPC),
        .q_o     (pc)
    );

    assign misaligned = |(bus.NextPC[1:0] & ALIGN_MASK);

    // State, captured instruction, counters and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            instr_q    <= '0;
            retired_q  <= '0;
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            addr_err_q <= addr_err_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state: the wait counter saturates at MAX_WAIT and flags the timeout as it gets there
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        addr_err_d = addr_err_q;
        timeout_d  = timeout_q;
        pc_load    = 1'b0;
        case (state_q)
            S_FETCH: if (bus.IMemReady) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: if (bus.IMemRespValid) begin
                instr_d = bus.IMemRData;
                state_d = S_HOLD;
            end else begin
                cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                timeout_d = timeout_q | (cnt_d == CNT_MAX);
            end
            S_HOLD: if (bus.InstrAccept) begin
                pc_load    = 1'b1;
                retired_d  = retired_q + 32'd1;
                state_d    = misaligned ? S_ERR : S_FETCH;
                addr_err_d = addr_err_q | misaligned;
            end
            default: ;
        endcase
    end

    assign bus.IMemReq      = (state_q == S_FETCH) && reset_n;
    assign bus.IMemAddr     = pc;
    assign bus.CurrentPC    = pc;
    assign bus.InstrValid   = (state_q == S_HOLD);
    assign bus.Instr        = instr_q;
    assign bus.AddrErr      = addr_err_q;
    assign bus.FetchTimeout = timeout_q;
    assign bus.RetiredCount = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written corner sequences for fetch_unit
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit_if b1 ();
    fetch_unit_if b2 ();

    fetch_unit dut (.clk(clk), .reset_n(reset_n), .bus(b1));
    fetch_unit #(.MAX_WAIT(4)) dut_w4 (.clk(clk), .reset_n(reset_n), .bus(b2));

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        acc;
        logic [31:0] npc;
        logic        e_req;
        logic        e_iv;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_ret;
        logic        e_ae;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rdata, logic acc, logic [31:0] npc,
                                logic req, logic iv, logic [31:0] addr, logic [31:0] instr,
                                logic [31:0] ret, logic ae);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.acc = acc; v.npc = npc;
        v.e_req = req; v.e_iv = iv; v.e_addr = addr; v.e_instr = instr; v.e_ret = ret; v.e_ae = ae;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic rdy, logic rv, logic [31:0] rdata, logic acc, logic [31:0] npc);
        b1.IMemReady = rdy;
        b1.IMemRespValid = rv;
        b1.IMemRData = rdata;
        b1.InstrAccept = acc;
        b1.NextPC = npc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        b2.IMemReady = 1'b0;
        b2.IMemRespValid = 1'b0;
        b2.IMemRData = 32'h0;
        b2.InstrAccept = 1'b0;
        b2.NextPC = 32'h0;

        tv.push_back(mk(1, 0, 32'h0,        0, 32'h0,    0, 0, 32'h3000, 32'h0,        0, 0));
        tv.push_back(mk(0, 1, 32'h3c010001, 0, 32'h0,    0, 1, 32'h3000, 32'h3c010001, 0, 0));
        tv.push_back(mk(0, 0, 32'h0,        1, 32'h3004, 1, 0, 32'h3004, 32'h3c010001, 1, 0));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h3004, 32'h3c010001, 1, 0));
        tv.push_back(mk(1, 0, 32'h0,        0, 32'h0,    0, 0, 32'h3004, 32'h3c010001, 1, 0));
        tv.push_back(mk(0, 1, 32'haabbccdd, 0, 32'h0,    0, 1, 32'h3004, 32'haabbccdd, 1, 0));
        for (int i = 0; i < 10; i++)
            tv.push_back(mk(0, 0, 32'h0, 0, (i % 2) ? 32'h1111_0001 : 32'h3010,
                            0, 1, 32'h3004, 32'haabbccdd, 1, 0));
        tv.push_back(mk(0, 0, 32'h0,        1, 32'h3010, 1, 0, 32'h3010, 32'haabbccdd, 2, 0));
        tv.push_back(mk(1, 1, 32'hdeadbeef, 1, 32'h3002, 0, 0, 32'h3010, 32'haabbccdd, 2, 0));
        tv.push_back(mk(0, 1, 32'h12345678, 0, 32'h0,    0, 1, 32'h3010, 32'h12345678, 2, 0));
        tv.push_back(mk(0, 0, 32'h0,        1, 32'h3002, 0, 0, 32'h3002, 32'h12345678, 3, 1));
        tv.push_back(mk(1, 1, 32'h0,        1, 32'h3004, 0, 0, 32'h3002, 32'h12345678, 3, 1));
        tv.push_back(mk(1, 1, 32'h0,        1, 32'h3004, 0, 0, 32'h3002, 32'h12345678, 3, 1));

        tick();
        tick();
        chk("rst.req",   {31'h0, b1.IMemReq},     32'h0);
        chk("rst.iv",    {31'h0, b1.InstrValid},  32'h0);
        chk("rst.addr",  b1.IMemAddr,             32'h3000);
        chk("rst.instr", b1.Instr,                32'h0);
        chk("rst.ret",   b1.RetiredCount,         32'h0);
        chk("rst.ae",    {31'h0, b1.AddrErr},     32'h0);
        chk("rst.to",    {31'h0, b1.FetchTimeout}, 32'h0);

        reset_n = 1'b1;
        #1;
        chk("rel.req",  {31'h0, b1.IMemReq}, 32'h1);
        chk("rel.addr", b1.IMemAddr,         32'h3000);

        foreach (tv[i]) begin
            drive(tv[i].rdy, tv[i].rv, tv[i].rdata, tv[i].acc, tv[i].npc);
            tick();
            chk($sformatf("vec%0d.req", i),   {31'h0, b1.IMemReq},    {31'h0, tv[i].e_req});
            chk($sformatf("vec%0d.iv", i),    {31'h0, b1.InstrValid}, {31'h0, tv[i].e_iv});
            chk($sformatf("vec%0d.addr", i),  b1.IMemAddr,            tv[i].e_addr);
            chk($sformatf("vec%0d.cpc", i),   b1.CurrentPC,           tv[i].e_addr);
            chk($sformatf("vec%0d.instr", i), b1.Instr,               tv[i].e_instr);
            chk($sformatf("vec%0d.ret", i),   b1.RetiredCount,        tv[i].e_ret);
            chk($sformatf("vec%0d.ae", i),    {31'h0, b1.AddrErr},    {31'h0, tv[i].e_ae});
        end

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("errrst.req",  {31'h0, b1.IMemReq}, 32'h0);
        chk("errrst.addr", b1.IMemAddr,         32'h3000);
        chk("errrst.ae",   {31'h0, b1.AddrErr}, 32'h0);
        chk("errrst.ret",  b1.RetiredCount,     32'h0);
        tick();
        reset_n = 1'b1;

        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("midw.req", {31'h0, b1.IMemReq}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midw.rstreq", {31'h0, b1.IMemReq}, 32'h0);
        tick();
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 32'hcafef00d, 1'b0, 32'h0);
        tick();
        chk("stale.req",   {31'h0, b1.IMemReq},    32'h1);
        chk("stale.iv",    {31'h0, b1.InstrValid}, 32'h0);
        chk("stale.addr",  b1.IMemAddr,            32'h3000);
        chk("stale.instr", b1.Instr,               32'h0);

        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0011, 1'b0, 32'h0);
        tick();
        chk("wrap.iv",    {31'h0, b1.InstrValid}, 32'h1);
        chk("wrap.instr", b1.Instr,               32'h0000_0011);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        force dut.retired_q = 32'hffff_ffff;
        #1;
        release dut.retired_q;
        #1;
        chk("wrap.pre", b1.RetiredCount, 32'hffff_ffff);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3008);
        tick();
        chk("wrap.ret",  b1.RetiredCount, 32'h0);
        chk("wrap.addr", b1.IMemAddr,     32'h3008);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        b2.IMemReady = 1'b1;
        tick();
        b2.IMemReady = 1'b0;
        chk("to.enter", {31'h0, b2.FetchTimeout}, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("to.cyc%0d", k), {31'h0, b2.FetchTimeout}, (k >= 4) ? 32'h1 : 32'h0);
            chk($sformatf("to.iv%0d", k),  {31'h0, b2.InstrValid},   32'h0);
        end
        b2.IMemRespValid = 1'b1;
        b2.IMemRData = 32'h0000_0077;
        tick();
        b2.IMemRespValid = 1'b0;
        chk("to.hold",  {31'h0, b2.InstrValid},   32'h1);
        chk("to.instr", b2.Instr,                 32'h0000_0077);
        chk("to.stick", {31'h0, b2.FetchTimeout}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
